// File: rtl/fpu_issue_ctrl.sv
// Issue/sequence controller between scalar decode and the single-cycle FPU.
// Optional sticky fflags accumulator is built when FPU_FFLAGS_ACC_EN is defined.
module fpu_issue_ctrl #(
  parameter int std   = 31,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_op,
  input  logic [2:0]       req_rm,
  input  logic [std:0]     req_a,
  input  logic [std:0]     req_b,
  input  logic [std:0]     req_c,
  input  logic [31:0]      req_int,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [2:0]       csr_frm,
  output logic [23:0]      fpu_op,
  output logic [2:0]       fpu_frm,
  output logic [std:0]     fpu_a,
  output logic [std:0]     fpu_b,
  output logic [std:0]     fpu_c,
  output logic [31:0]      fpu_int,
  output logic [2:0]       fpu_sel,
  input  logic [std:0]     fpu_resultant,
  input  logic [31:0]      fpu_result_rd,
  input  logic [4:0]       fpu_flags,
  input  logic             fpu_irq,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_to_int,
  output logic [4:0]       rsp_flags,
  output logic             rsp_irq,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag
`ifdef FPU_FFLAGS_ACC_EN
  ,
  output logic [4:0]       fflags,
  input  logic             fflags_clr
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  // Ops whose result goes to the integer register file (compares, classify, FP->int moves/converts).
  localparam logic [21:0] TO_INT_MASK = (22'd1 << 21) | (22'd1 << 14) | (22'd1 << 11) |
                                        (22'd1 << 10) | (22'd1 << 9)  | (22'd1 << 7);

  state_t      state;
  logic [2:0]  eff_rm;
  logic        req_bad;
  logic        cap_to_int;

  assign eff_rm     = (req_rm == 3'b111) ? csr_frm : req_rm;
  assign req_bad    = ($countones(req_op[21:0]) != 1) ||
                      (eff_rm == 3'b101) || (eff_rm == 3'b110) || (eff_rm == 3'b111);
  assign cap_to_int = |(fpu_op[21:0] & TO_INT_MASK);

  // The fpu_* output registers double as the operand latches; they are only
  // loaded for legal requests so the FPU never sees a rejected operation.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      fpu_op      <= '0;
      fpu_frm     <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      fpu_c       <= '0;
      fpu_int     <= '0;
      fpu_sel     <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_to_int  <= 1'b0;
      rsp_flags   <= '0;
      rsp_irq     <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_tag     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_tag   <= req_tag;
            if (req_bad) begin
              rsp_valid   <= 1'b1;
              rsp_illegal <= 1'b1;
              rsp_data    <= '0;
              rsp_flags   <= '0;
              rsp_to_int  <= 1'b0;
              rsp_irq     <= 1'b0;
              state       <= RESP;
            end else begin
              fpu_op  <= req_op;
              fpu_frm <= eff_rm;
              fpu_a   <= req_a;
              fpu_b   <= req_b;
              fpu_c   <= req_c;
              fpu_int <= req_int;
              fpu_sel <= 3'b010;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: state <= CAPT;
        // fpu_result_rd depends combinationally on the opcode, so the bus stays driven through CAPT.
        CAPT: begin
          rsp_to_int  <= cap_to_int;
          rsp_data    <= cap_to_int ? fpu_result_rd : 32'(fpu_resultant);
          rsp_flags   <= fpu_flags;
          rsp_irq     <= fpu_irq;
          rsp_illegal <= 1'b0;
          rsp_valid   <= 1'b1;
          fpu_op      <= '0;
          fpu_sel     <= '0;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPU_FFLAGS_ACC_EN
  // Clear takes effect before the OR, so a clear coinciding with a handshake keeps that op's flags.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      fflags <= '0;
    else
      fflags <= (fflags_clr ? 5'd0 : fflags) | ((rsp_valid && rsp_ready) ? rsp_flags : 5'd0);
  end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl; the bench itself plays the FPU.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        req_valid, req_ready;
  logic [23:0] req_op;
  logic [2:0]  req_rm, csr_frm;
  logic [31:0] req_a, req_b, req_c, req_int;
  logic [4:0]  req_tag;
  logic [23:0] fpu_op;
  logic [2:0]  fpu_frm, fpu_sel;
  logic [31:0] fpu_a, fpu_b, fpu_c, fpu_int;
  logic [31:0] fpu_resultant, fpu_result_rd;
  logic [4:0]  fpu_flags;
  logic        fpu_irq;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_to_int, rsp_irq, rsp_illegal;
  logic [4:0]  rsp_flags, rsp_tag;
`ifdef FPU_FFLAGS_ACC_EN
  logic [4:0]  fflags;
  logic        fflags_clr;
`endif

  int vectors = 0;
  int miscompares = 0;

  fpu_issue_ctrl #(.std(31), .TAG_W(5)) dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_int(req_int), .req_tag(req_tag),
    .csr_frm(csr_frm),
    .fpu_op(fpu_op), .fpu_frm(fpu_frm), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c),
    .fpu_int(fpu_int), .fpu_sel(fpu_sel),
    .fpu_resultant(fpu_resultant), .fpu_result_rd(fpu_result_rd),
    .fpu_flags(fpu_flags), .fpu_irq(fpu_irq),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_to_int(rsp_to_int), .rsp_flags(rsp_flags), .rsp_irq(rsp_irq),
    .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag)
`ifdef FPU_FFLAGS_ACC_EN
    , .fflags(fflags), .fflags_clr(fflags_clr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] op;
    logic [2:0]  rm;
    logic [2:0]  csr;
    logic        bad;
    logic [2:0]  frm;
  } vec_t;

  vec_t rej_vecs[8] = '{
    '{24'h000003, 3'b000, 3'b000, 1'b1, 3'b000},
    '{24'h000000, 3'b000, 3'b000, 1'b1, 3'b000},
    '{24'h000001, 3'b101, 3'b000, 1'b1, 3'b000},
    '{24'h000001, 3'b110, 3'b000, 1'b1, 3'b000},
    '{24'h000001, 3'b111, 3'b110, 1'b1, 3'b000},
    '{24'h000001, 3'b111, 3'b111, 1'b1, 3'b000},
    '{24'h000010, 3'b100, 3'b000, 1'b0, 3'b100},
    '{24'hE00000, 3'b111, 3'b100, 1'b0, 3'b100}
  };

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic send_req(input logic [23:0] op, input logic [2:0] rm,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    req_valid = 1'b1; req_op = op; req_rm = rm; req_a = a; req_b = b;
    req_c = a ^ b; req_int = ~a; req_tag = tag;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready); end
    vectors++; if ({rsp_valid, rsp_illegal, rsp_to_int, rsp_irq, rsp_flags, rsp_data} !== '0) begin miscompares++; $display("[TB] FAIL reset_rsp: got %b %h want all zero", {rsp_valid, rsp_illegal, rsp_to_int, rsp_irq, rsp_flags}, rsp_data); end
    vectors++; if ({fpu_op, fpu_sel, fpu_frm} !== '0) begin miscompares++; $display("[TB] FAIL reset_fpu: got op %h sel %b frm %b want 0", fpu_op, fpu_sel, fpu_frm); end
`ifdef FPU_FFLAGS_ACC_EN
    vectors++; if (fflags !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_fflags: got %b want 0", fflags); end
`endif
  endtask

  task automatic test_fadd;
    fpu_resultant = 32'h4040_0000; fpu_result_rd = 32'h0000_DEAD; fpu_flags = 5'd0; fpu_irq = 1'b0;
    send_req(24'h000001, 3'b000, 32'h3F80_0000, 32'h4000_0000, 5'd3);
    vectors++; if (fpu_op !== 24'h000001) begin miscompares++; $display("[TB] FAIL fadd_issue_op: got %h want 000001", fpu_op); end
    vectors++; if (fpu_sel !== 3'b010) begin miscompares++; $display("[TB] FAIL fadd_issue_sel: got %b want 010", fpu_sel); end
    vectors++; if ({fpu_a, fpu_b, fpu_c, fpu_int} !== {32'h3F80_0000, 32'h4000_0000, 32'h7F80_0000, 32'hC07F_FFFF}) begin miscompares++; $display("[TB] FAIL fadd_operands: got %h %h %h %h", fpu_a, fpu_b, fpu_c, fpu_int); end
    vectors++; if ({req_ready, rsp_valid, fpu_frm} !== 5'b00_000) begin miscompares++; $display("[TB] FAIL fadd_issue_hs: got rdy %b vld %b frm %b want 0 0 000", req_ready, rsp_valid, fpu_frm); end
    @(negedge clk);
    vectors++; if ({fpu_op, fpu_sel, rsp_valid} !== {24'h000001, 3'b010, 1'b0}) begin miscompares++; $display("[TB] FAIL fadd_capt: got op %h sel %b vld %b want 000001 010 0", fpu_op, fpu_sel, rsp_valid); end
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL fadd_rsp_valid: got %b want 1", rsp_valid); end
    vectors++; if (rsp_data !== 32'h4040_0000) begin miscompares++; $display("[TB] FAIL fadd_rsp_data: got %h want 40400000", rsp_data); end
    vectors++; if ({rsp_to_int, rsp_illegal, rsp_irq, rsp_flags, rsp_tag} !== {3'b000, 5'd0, 5'd3}) begin miscompares++; $display("[TB] FAIL fadd_rsp_fields: got int %b ill %b irq %b flg %b tag %0d", rsp_to_int, rsp_illegal, rsp_irq, rsp_flags, rsp_tag); end
    vectors++; if ({fpu_op, fpu_sel} !== 27'd0) begin miscompares++; $display("[TB] FAIL fadd_resp_fpu_idle: got op %h sel %b want 0", fpu_op, fpu_sel); end
    finish_rsp;
    vectors++; if ({rsp_valid, req_ready} !== 2'b01) begin miscompares++; $display("[TB] FAIL fadd_after_hs: got vld %b rdy %b want 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_flt_backpressure;
    fpu_resultant = 32'h1234_5678; fpu_result_rd = 32'h0000_0001; fpu_flags = 5'b00010; fpu_irq = 1'b1;
    send_req(24'h000400, 3'b001, 32'h3F80_0000, 32'h4000_0000, 5'd7);
    @(negedge clk); @(negedge clk);
    fpu_resultant = 32'hFFFF_FFFF; fpu_result_rd = 32'hFFFF_FFFF; fpu_flags = 5'b11111; fpu_irq = 1'b0;
    req_valid = 1'b1; req_op = 24'h000001; req_rm = 3'b000;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid, rsp_to_int, rsp_illegal, rsp_irq, rsp_flags, rsp_tag, rsp_data, req_ready} !==
          {1'b1, 1'b1, 1'b0, 1'b1, 5'b00010, 5'd7, 32'h0000_0001, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL flt_hold[%0d]: got vld %b int %b ill %b irq %b flg %b tag %0d data %h rdy %b", i,
                 rsp_valid, rsp_to_int, rsp_illegal, rsp_irq, rsp_flags, rsp_tag, rsp_data, req_ready);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    finish_rsp;
    vectors++; if ({rsp_valid, req_ready, fpu_sel} !== 5'b01_000) begin miscompares++; $display("[TB] FAIL flt_after_hs: got vld %b rdy %b sel %b want 0 1 000", rsp_valid, req_ready, fpu_sel); end
  endtask

  task automatic test_dyn_rm;
    csr_frm = 3'b011; fpu_flags = 5'd0; fpu_irq = 1'b0;
    send_req(24'h000002, 3'b111, 32'h1, 32'h2, 5'd9);
    vectors++; if ({fpu_op, fpu_frm} !== {24'h000002, 3'b011}) begin miscompares++; $display("[TB] FAIL dyn_frm: got op %h frm %b want 000002 011", fpu_op, fpu_frm); end
    @(negedge clk); @(negedge clk);
    finish_rsp;
    csr_frm = 3'b101; fpu_flags = 5'b11111; fpu_resultant = 32'hFFFF_FFFF;
    send_req(24'h000001, 3'b111, 32'h1, 32'h2, 5'd12);
    vectors++; if ({rsp_valid, rsp_illegal} !== 2'b11) begin miscompares++; $display("[TB] FAIL dyn_illegal: got vld %b ill %b want 1 1", rsp_valid, rsp_illegal); end
    vectors++; if ({rsp_data, rsp_flags, rsp_to_int, rsp_tag} !== {32'd0, 5'd0, 1'b0, 5'd12}) begin miscompares++; $display("[TB] FAIL dyn_illegal_fields: got data %h flg %b int %b tag %0d", rsp_data, rsp_flags, rsp_to_int, rsp_tag); end
    vectors++; if ({fpu_op, fpu_sel} !== 27'd0) begin miscompares++; $display("[TB] FAIL dyn_illegal_fpu: got op %h sel %b want 0", fpu_op, fpu_sel); end
    @(negedge clk);
    vectors++; if ({fpu_op, fpu_sel, rsp_valid} !== {27'd0, 1'b1}) begin miscompares++; $display("[TB] FAIL dyn_illegal_hold: got op %h sel %b vld %b", fpu_op, fpu_sel, rsp_valid); end
    finish_rsp;
  endtask

  task automatic test_reject;
    fpu_flags = 5'd0;
    for (int i = 0; i < 8; i++) begin
      csr_frm = rej_vecs[i].csr;
      send_req(rej_vecs[i].op, rej_vecs[i].rm, 32'h5, 32'h6, 5'(i));
      if (rej_vecs[i].bad) begin
        vectors++; if ({rsp_valid, rsp_illegal, fpu_sel, fpu_op} !== {2'b11, 27'd0}) begin miscompares++; $display("[TB] FAIL reject[%0d]: got vld %b ill %b sel %b op %h want 1 1 0 0", i, rsp_valid, rsp_illegal, fpu_sel, fpu_op); end
      end else begin
        vectors++; if ({rsp_valid, fpu_sel, fpu_frm, fpu_op} !== {1'b0, 3'b010, rej_vecs[i].frm, rej_vecs[i].op}) begin miscompares++; $display("[TB] FAIL accept[%0d]: got vld %b sel %b frm %b op %h", i, rsp_valid, fpu_sel, fpu_frm, fpu_op); end
        @(negedge clk); @(negedge clk);
        vectors++; if ({rsp_valid, rsp_illegal} !== 2'b10) begin miscompares++; $display("[TB] FAIL accept_rsp[%0d]: got vld %b ill %b want 1 0", i, rsp_valid, rsp_illegal); end
      end
      finish_rsp;
    end
  endtask

  task automatic test_to_int_map;
    logic [23:0] op;
    logic        exp_int;
    logic [31:0] exp_data;
    for (int b = 0; b < 22; b++) begin
      op = (24'd1 << b) | ((b % 2 == 1) ? 24'h400000 : 24'h800000);
      exp_int = (b == 7) || (b == 9) || (b == 10) || (b == 11) || (b == 14) || (b == 21);
      fpu_resultant = 32'h5A5A_0000 | 32'(b);
      fpu_result_rd = 32'hA5A5_0000 | 32'(b);
      fpu_flags = 5'(b);
      fpu_irq = (b % 2 == 1);
      exp_data = exp_int ? (32'hA5A5_0000 | 32'(b)) : (32'h5A5A_0000 | 32'(b));
      send_req(op, 3'b010, 32'h0, 32'h0, 5'(b));
      vectors++; if (fpu_op !== op) begin miscompares++; $display("[TB] FAIL map_op[%0d]: got %h want %h", b, fpu_op, op); end
      @(negedge clk); @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_to_int, rsp_data, rsp_irq, rsp_flags, rsp_tag} !==
          {1'b1, exp_int, exp_data, (b % 2 == 1), 5'(b), 5'(b)}) begin
        miscompares++;
        $display("[TB] FAIL map_rsp[%0d]: got vld %b int %b data %h irq %b flg %b tag %0d want int %b data %h",
                 b, rsp_valid, rsp_to_int, rsp_data, rsp_irq, rsp_flags, rsp_tag, exp_int, exp_data);
      end
      finish_rsp;
    end
  endtask

`ifdef FPU_FFLAGS_ACC_EN
  task automatic flag_op(input logic [23:0] op, input logic [4:0] flags, input logic clr);
    fpu_flags = flags;
    send_req(op, 3'b000, 32'h3FC0_0000, 32'h0, 5'd1);
    @(negedge clk); @(negedge clk);
    rsp_ready = 1'b1; fflags_clr = clr;
    @(posedge clk); #1 rsp_ready = 1'b0; fflags_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fflags;
    flag_op(24'h000080, 5'b00001, 1'b0);
    vectors++; if (fflags !== 5'b00001) begin miscompares++; $display("[TB] FAIL fflags_cvt: got %b want 00001", fflags); end
    flag_op(24'h000008, 5'b01000, 1'b0);
    vectors++; if (fflags !== 5'b01001) begin miscompares++; $display("[TB] FAIL fflags_div: got %b want 01001", fflags); end
    fflags_clr = 1'b1; @(posedge clk); #1 fflags_clr = 1'b0; @(negedge clk);
    vectors++; if (fflags !== 5'b00000) begin miscompares++; $display("[TB] FAIL fflags_clr_alone: got %b want 00000", fflags); end
    fpu_flags = 5'b11111;
    send_req(24'h000003, 3'b000, 32'h0, 32'h0, 5'd2);
    finish_rsp;
    vectors++; if (fflags !== 5'b00000) begin miscompares++; $display("[TB] FAIL fflags_illegal: got %b want 00000", fflags); end
    flag_op(24'h000001, 5'b00100, 1'b0);
    vectors++; if (fflags !== 5'b00100) begin miscompares++; $display("[TB] FAIL fflags_acc: got %b want 00100", fflags); end
    flag_op(24'h000001, 5'b10000, 1'b1);
    vectors++; if (fflags !== 5'b10000) begin miscompares++; $display("[TB] FAIL fflags_clr_hs: got %b want 10000", fflags); end
  endtask
`endif

  task automatic test_reset_capt;
    fpu_flags = 5'b00011;
    send_req(24'h000001, 3'b000, 32'h1, 32'h2, 5'd4);
    @(negedge clk);
    rst_l = 1'b0;
    #2;
    vectors++; if ({rsp_valid, req_ready, fpu_op, fpu_sel} !== {1'b0, 1'b1, 27'd0}) begin miscompares++; $display("[TB] FAIL rst_capt: got vld %b rdy %b op %h sel %b want 0 1 0 0", rsp_valid, req_ready, fpu_op, fpu_sel); end
`ifdef FPU_FFLAGS_ACC_EN
    vectors++; if (fflags !== 5'd0) begin miscompares++; $display("[TB] FAIL rst_capt_fflags: got %b want 0", fflags); end
`endif
    @(negedge clk); rst_l = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if ({rsp_valid, req_ready} !== 2'b01) begin miscompares++; $display("[TB] FAIL rst_capt_settle: got vld %b rdy %b want 0 1", rsp_valid, req_ready); end
  endtask

  initial begin
    rst_l = 1'b0; req_valid = 1'b0; req_op = '0; req_rm = '0; req_a = '0; req_b = '0;
    req_c = '0; req_int = '0; req_tag = '0; csr_frm = '0; rsp_ready = 1'b0;
    fpu_resultant = '0; fpu_result_rd = '0; fpu_flags = '0; fpu_irq = 1'b0;
`ifdef FPU_FFLAGS_ACC_EN
    fflags_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    test_reset;
    test_fadd;
    test_flt_backpressure;
    test_dyn_rm;
    test_reject;
    test_to_int_map;
`ifdef FPU_FFLAGS_ACC_EN
    test_fflags;
`endif
    test_reset_capt;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
